// File: rtl/apu_pkg.sv
// Shared APU voice types: ADSR state enum and software-visible phase codes.
package apu_pkg;

    typedef enum logic [2:0] {
        ADSR_IDLE    = 3'd0,
        ADSR_ATTACK  = 3'd1,
        ADSR_DECAY   = 3'd2,
        ADSR_SUSTAIN = 3'd3,
        ADSR_RELEASE = 3'd4
    } adsr_state_t;

    localparam logic [2:0] ADSR_PHASE_IDLE    = 3'd0;
    localparam logic [2:0] ADSR_PHASE_ATTACK  = 3'd1;
    localparam logic [2:0] ADSR_PHASE_DECAY   = 3'd2;
    localparam logic [2:0] ADSR_PHASE_SUSTAIN = 3'd3;
    localparam logic [2:0] ADSR_PHASE_RELEASE = 3'd4;

endpackage

// File: rtl/envelope_scaler.sv
// Registered signed-sample x unsigned-gain multiply; gain is the top 16 envelope bits.
module envelope_scaler #(
    parameter int SAMPLE_WIDTH = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [SAMPLE_WIDTH-1:0] sample_i,
    input  logic [15:0]             gain_i,
    output logic [SAMPLE_WIDTH-1:0] sample_o
);

    logic signed [SAMPLE_WIDTH+16:0] prod;
    logic                            prod_unused;

    // Zero-extended gain keeps the multiply signed x unsigned; |result| <= |sample|.
    assign prod        = $signed(sample_i) * $signed({1'b0, gain_i});
    assign prod_unused = ^{prod[SAMPLE_WIDTH+16], prod[15:0]};

    always_ff @(posedge clk_i) begin
        if (rst_i) sample_o <= '0;
        else       sample_o <= prod[SAMPLE_WIDTH+15:16];
    end

endmodule

// File: rtl/adsr_envelope.sv
// ADSR envelope generator for one APU voice, advanced on sample_tick_i.
// Optional ADSR_ENVELOPE_APPLY_EN scales sample_i by the envelope; otherwise sample_i is registered through.
module adsr_envelope #(
    parameter int ENV_WIDTH    = 32,
    parameter int SAMPLE_WIDTH = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    sample_tick_i,
    input  logic                    adsr_enable_i,
    input  logic                    adsr_start_i,
    input  logic [ENV_WIDTH-1:0]    attack_step_i,
    input  logic [ENV_WIDTH-1:0]    decay_step_i,
    input  logic [ENV_WIDTH-1:0]    release_step_i,
    input  logic [ENV_WIDTH-1:0]    sustain_duration_i,
    input  logic [ENV_WIDTH-1:0]    attack_level_i,
    input  logic [ENV_WIDTH-1:0]    sustain_level_i,
    input  logic [SAMPLE_WIDTH-1:0] sample_i,
    output logic [ENV_WIDTH-1:0]    envelope_o,
    output logic [2:0]              phase_o,
    output logic                    adsr_idle_o,
    output logic [SAMPLE_WIDTH-1:0] sample_o
);
    import apu_pkg::*;

    adsr_state_t          state;
    logic [ENV_WIDTH-1:0] env;
    logic [ENV_WIDTH-1:0] sus_cnt;
    logic [ENV_WIDTH:0]   att_sum;
    logic [ENV_WIDTH:0]   dec_floor;

    // One extra bit so level + step comparisons never wrap.
    assign att_sum   = {1'b0, env} + {1'b0, attack_step_i};
    assign dec_floor = {1'b0, sustain_level_i} + {1'b0, decay_step_i};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= ADSR_IDLE;
            env     <= '0;
            sus_cnt <= '0;
        end else if (!adsr_enable_i) begin
            state <= ADSR_IDLE;
            env   <= '0;
        end else if (adsr_start_i) begin
            // Retrigger keeps the current level to avoid a click.
            state <= ADSR_ATTACK;
        end else if (sample_tick_i) begin
            case (state)
                ADSR_ATTACK: begin
                    if (att_sum >= {1'b0, attack_level_i}) begin
                        env   <= attack_level_i;
                        state <= ADSR_DECAY;
                    end else begin
                        env <= att_sum[ENV_WIDTH-1:0];
                    end
                end
                ADSR_DECAY: begin
                    if ({1'b0, env} <= dec_floor) begin
                        env     <= sustain_level_i;
                        sus_cnt <= sustain_duration_i;
                        state   <= ADSR_SUSTAIN;
                    end else begin
                        env <= env - decay_step_i;
                    end
                end
                ADSR_SUSTAIN: begin
                    if (sus_cnt == '0) state <= ADSR_RELEASE;
                    else               sus_cnt <= sus_cnt - 1'b1;
                end
                ADSR_RELEASE: begin
                    if (env <= release_step_i) begin
                        env   <= '0;
                        state <= ADSR_IDLE;
                    end else begin
                        env <= env - release_step_i;
                    end
                end
                default: ;
            endcase
        end
    end

    assign envelope_o  = env;
    assign phase_o     = state;
    assign adsr_idle_o = (state == ADSR_IDLE);

`ifdef ADSR_ENVELOPE_APPLY_EN
    envelope_scaler #(.SAMPLE_WIDTH(SAMPLE_WIDTH)) u_scaler (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .sample_i (sample_i),
        .gain_i   (env[ENV_WIDTH-1 -: 16]),
        .sample_o (sample_o)
    );
`else
    always_ff @(posedge clk_i) begin
        if (rst_i) sample_o <= '0;
        else       sample_o <= sample_i;
    end
`endif

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed bench for adsr_envelope; expected values hand-derived from the envelope rules.
module tb_adsr_envelope;

    logic        clk = 1'b0;
    logic        rst, tick, en, start;
    logic [31:0] att_step, dec_step, rel_step, sus_dur, att_lvl, sus_lvl;
    logic [15:0] smp_in;
    logic [31:0] env;
    logic [2:0]  phase;
    logic        idle;
    logic [15:0] smp_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    adsr_envelope #(.ENV_WIDTH(32), .SAMPLE_WIDTH(16)) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .sample_tick_i      (tick),
        .adsr_enable_i      (en),
        .adsr_start_i       (start),
        .attack_step_i      (att_step),
        .decay_step_i       (dec_step),
        .release_step_i     (rel_step),
        .sustain_duration_i (sus_dur),
        .attack_level_i     (att_lvl),
        .sustain_level_i    (sus_lvl),
        .sample_i           (smp_in),
        .envelope_o         (env),
        .phase_o            (phase),
        .adsr_idle_o        (idle),
        .sample_o           (smp_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [31:0] e, input logic [2:0] p);
        check({tag, "_env"}, env, e);
        check({tag, "_phase"}, {29'd0, phase}, {29'd0, p});
        check({tag, "_idle"}, {31'd0, idle}, {31'd0, (p == 3'd0)});
    endtask

    // One clock with the given start/tick, then sample 1 time unit after the edge.
    task automatic cyc(input logic s, input logic t);
        start = s;
        tick  = t;
        @(posedge clk);
        #1;
        start = 1'b0;
        tick  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; en = 1'b0; start = 1'b0;
        att_step = 32'h1000_0000; att_lvl = 32'h8000_0000;
        dec_step = 32'h1000_0000; sus_lvl = 32'h5000_0000; sus_dur = 32'd2;
        rel_step = 32'h3000_0000; smp_in = 16'h1234;
        cyc(0, 0);
        cyc(0, 0);
        chk_state("reset", 32'h0, 3'd0);
        check("reset_sample", {16'd0, smp_out}, 32'h0);

        rst = 1'b0; en = 1'b1;
        cyc(1, 0);
        chk_state("start", 32'h0, 3'd1);

        for (int i = 1; i <= 8; i++) begin
            cyc(0, 1);
            chk_state("attack", 32'(i) << 28, (i == 8) ? 3'd2 : 3'd1);
        end

        cyc(0, 1); chk_state("decay1", 32'h7000_0000, 3'd2);
        cyc(0, 1); chk_state("decay2", 32'h6000_0000, 3'd2);
        cyc(0, 1); chk_state("decay3", 32'h5000_0000, 3'd3);

        cyc(0, 1); chk_state("sus1", 32'h5000_0000, 3'd3);
        cyc(0, 1); chk_state("sus2", 32'h5000_0000, 3'd3);
        cyc(0, 1); chk_state("sus3", 32'h5000_0000, 3'd4);
        cyc(0, 0); chk_state("no_tick_hold", 32'h5000_0000, 3'd4);

        cyc(0, 1); chk_state("rel1", 32'h2000_0000, 3'd4);
        cyc(0, 1); chk_state("rel2", 32'h0, 3'd0);
        cyc(0, 1); chk_state("idle_tick", 32'h0, 3'd0);

        // Walk back into RELEASE at 0x2000_0000 using large steps.
        att_step = 32'h8000_0000; dec_step = 32'h3000_0000; sus_dur = 32'd0;
        cyc(1, 0); chk_state("re_start", 32'h0, 3'd1);
        cyc(0, 1); chk_state("re_att", 32'h8000_0000, 3'd2);
        cyc(0, 1); chk_state("re_dec", 32'h5000_0000, 3'd3);
        cyc(0, 1); chk_state("re_sus0", 32'h5000_0000, 3'd4);
        cyc(0, 1); chk_state("re_rel", 32'h2000_0000, 3'd4);

        att_step = 32'h1000_0000;
        cyc(1, 1); chk_state("retrig", 32'h2000_0000, 3'd1);
        cyc(0, 1); chk_state("retrig_att", 32'h3000_0000, 3'd1);
        cyc(1, 1); chk_state("start_in_att", 32'h3000_0000, 3'd1);

        // Level already above the new peak: first tick clamps down.
        att_lvl = 32'h2000_0000; dec_step = 32'h0800_0000; sus_lvl = 32'h0;
        cyc(0, 1); chk_state("att_clamp", 32'h2000_0000, 3'd2);
        cyc(0, 1); chk_state("dec_mid", 32'h1800_0000, 3'd2);

        en = 1'b0;
        cyc(1, 1); chk_state("disable", 32'h0, 3'd0);
        en = 1'b1; att_lvl = 32'h8000_0000;
        cyc(1, 0); chk_state("restart", 32'h0, 3'd1);
        cyc(0, 1); chk_state("att_a", 32'h1000_0000, 3'd1);
        cyc(0, 1); chk_state("att_b", 32'h2000_0000, 3'd1);
        rst = 1'b1;
        cyc(0, 1); chk_state("mid_reset", 32'h0, 3'd0);
        check("mid_reset_sample", {16'd0, smp_out}, 32'h0);

        // Envelope at half scale, then sample path one cycle later.
        rst = 1'b0; att_step = 32'h8000_0000; dec_step = 32'h0;
        cyc(1, 0);
        cyc(0, 1); chk_state("half", 32'h8000_0000, 3'd2);
        smp_in = 16'h4000;
        cyc(0, 1);
        check("zero_step_stall", env, 32'h8000_0000);
`ifdef ADSR_ENVELOPE_APPLY_EN
        check("sample_scaled", {16'd0, smp_out}, 32'h0000_2000);
`else
        check("sample_pass", {16'd0, smp_out}, 32'h0000_4000);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
